// File: rtl/ovl_pkg.sv
// Shared types and helpers for the overlay layer arbiter.
package ovl_pkg;
  localparam int OVL_NL   = 5;
  localparam int OVL_IDXW = $clog2(OVL_NL);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } t_rgb;

  typedef logic [OVL_NL-1:0][OVL_IDXW-1:0] t_prio;

  typedef enum logic [1:0] {IDLE, PEND, APPLY} t_cfg_st;

  function automatic t_prio identity_prio();
    t_prio p;
    for (int k = 0; k < OVL_NL; k++) p[k] = OVL_IDXW'(k);
    return p;
  endfunction
endpackage

// File: rtl/overlay_sched_prio_pick.sv
// Combinational priority scan: first table entry naming a valid, enabled layer wins.
module prio_pick import ovl_pkg::*; (
  input  logic [OVL_NL*OVL_IDXW-1:0] prio,
  input  logic [OVL_NL-1:0]          en,
  output logic                       any,
  output logic [OVL_IDXW-1:0]        idx
);
  t_prio tbl;
  assign tbl = prio;

  // Scan from the lowest-priority entry up so the earliest match overrides later ones.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = OVL_NL - 1; i >= 0; i--) begin
      if (int'(tbl[i]) < OVL_NL && en[tbl[i]]) begin
        any = 1'b1;
        idx = tbl[i];
      end
    end
  end
endmodule

// File: rtl/overlay_sched.sv
// Two-stage per-pixel overlay compositor with a frame-synchronous priority table.
// Define OVL_STATS_EN to add per-layer per-frame win counters (stat_cnt/stat_valid).
module overlay_sched import ovl_pkg::*; #(
  parameter int N_LAYERS = OVL_NL,
  parameter int IDXW     = $clog2(N_LAYERS),
  parameter int CW       = 11,
  parameter int CNTW     = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CW-1:0]            x,
  input  logic [CW-1:0]            y,
  input  logic [N_LAYERS-1:0]      lay_en,
  input  logic [N_LAYERS*24-1:0]   lay_rgb,
  input  logic [23:0]              bg_rgb,
  input  logic                     cfg_valid,
  input  logic [N_LAYERS*IDXW-1:0] cfg_prio,
  output logic                     cfg_ready,
  output logic [7:0]               red,
  output logic [7:0]               green,
  output logic [7:0]               blue,
  output logic                     win_any,
  output logic [IDXW-1:0]          win_idx
`ifdef OVL_STATS_EN
  ,
  output logic [N_LAYERS*CNTW-1:0] stat_cnt,
  output logic                     stat_valid
`endif
);
  logic fs_in;
  assign fs_in = (x == '0) && (y == '0);

  logic [N_LAYERS-1:0] s1_en;
  t_rgb                s1_lay [N_LAYERS];
  t_rgb                s1_bg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_en <= '0;
      s1_bg <= '0;
      for (int k = 0; k < N_LAYERS; k++) s1_lay[k] <= '0;
    end else begin
      s1_en <= lay_en;
      s1_bg <= bg_rgb;
      for (int k = 0; k < N_LAYERS; k++) s1_lay[k] <= lay_rgb[24*k +: 24];
    end
  end

  t_cfg_st cfg_st;
  t_prio   pend_prio;
  t_prio   act_prio;

  // PEND watches the pixel entering stage 1; APPLY then swaps tables as that fs pixel
  // leaves stage 1, so only the pixels after it see the new table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_st    <= IDLE;
      cfg_ready <= 1'b0;
      pend_prio <= identity_prio();
      act_prio  <= identity_prio();
    end else begin
      case (cfg_st)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            pend_prio <= cfg_prio;
            cfg_ready <= 1'b0;
            cfg_st    <= PEND;
          end
        end
        PEND: begin
          if (fs_in) cfg_st <= APPLY;
        end
        APPLY: begin
          act_prio  <= pend_prio;
          cfg_ready <= 1'b1;
          cfg_st    <= IDLE;
        end
        default: cfg_st <= IDLE;
      endcase
    end
  end

  logic            pk_any;
  logic [IDXW-1:0] pk_idx;
  t_rgb            pk_rgb;

  prio_pick u_pick (
    .prio (act_prio),
    .en   (s1_en),
    .any  (pk_any),
    .idx  (pk_idx)
  );

  assign pk_rgb = pk_any ? s1_lay[pk_idx] : s1_bg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      win_any <= 1'b0;
      win_idx <= '0;
    end else begin
      red     <= pk_rgb.r;
      green   <= pk_rgb.g;
      blue    <= pk_rgb.b;
      win_any <= pk_any;
      win_idx <= pk_idx;
    end
  end

`ifdef OVL_STATS_EN
  logic            s1_fs;
  logic [CNTW-1:0] cnt [N_LAYERS];

  // Counting happens as each pixel moves into stage 2; the fs pixel starts a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_fs      <= 1'b0;
      stat_cnt   <= '0;
      stat_valid <= 1'b0;
      for (int k = 0; k < N_LAYERS; k++) cnt[k] <= '0;
    end else begin
      s1_fs      <= fs_in;
      stat_valid <= s1_fs;
      for (int k = 0; k < N_LAYERS; k++) begin
        if (s1_fs) begin
          stat_cnt[k*CNTW +: CNTW] <= cnt[k];
          cnt[k] <= (pk_any && pk_idx == IDXW'(k)) ? CNTW'(1) : '0;
        end else if (pk_any && pk_idx == IDXW'(k) && cnt[k] != '1) begin
          cnt[k] <= cnt[k] + CNTW'(1);
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_overlay_sched.sv
// Randomized bench for overlay_sched against a pixel-level reference model.
module tb_overlay_sched;
  localparam int NL = 5;
  localparam int IW = 3;
  localparam int CW = 11;
  localparam int CNTW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [CW-1:0]    x = '0, y = '0;
  logic [NL-1:0]    lay_en = '0;
  logic [NL*24-1:0] lay_rgb = '0;
  logic [23:0]      bg_rgb = '0;
  logic             cfg_valid = 1'b0;
  logic [NL*IW-1:0] cfg_prio = '0;
  logic             cfg_ready;
  logic [7:0]       red, green, blue;
  logic             win_any;
  logic [IW-1:0]    win_idx;
`ifdef OVL_STATS_EN
  logic [NL*CNTW-1:0] stat_cnt;
  logic               stat_valid;
`endif

  overlay_sched dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .lay_en(lay_en), .lay_rgb(lay_rgb),
    .bg_rgb(bg_rgb), .cfg_valid(cfg_valid), .cfg_prio(cfg_prio), .cfg_ready(cfg_ready),
    .red(red), .green(green), .blue(blue), .win_any(win_any), .win_idx(win_idx)
`ifdef OVL_STATS_EN
    , .stat_cnt(stat_cnt), .stat_valid(stat_valid)
`endif
  );

  typedef struct {
    logic [23:0] rgb;
    bit          any;
    int          idx;
    bit          fs;
    bit          lit;
    logic [23:0] lrgb;
    int          lidx;
    int          lst;
  } exp_t;

  int   tests = 0, fails = 0;
  int   tbl [NL];
  int   pend_tbl [NL];
  bit   pend;
  int   fs_c, cyc;
  bit   rdy_ok;
  int   px, py, fw, fh;
  exp_t q[$];
  longint fcnt [NL];
  longint st_exp [NL];
  bit          l_on;
  logic [23:0] l_rgb;
  int          l_idx, l_st;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Spec rule: first entry naming an existing, enabled layer wins.
  function automatic void pick(input int t [NL], input logic [NL-1:0] en, output bit any, output int idx);
    any = 0;
    idx = 0;
    for (int i = 0; i < NL; i++)
      if (!any && t[i] >= 0 && t[i] < NL) if (en[t[i]]) begin any = 1; idx = t[i]; end
  endfunction

  function automatic logic [NL*IW-1:0] tab(input int a, input int b, input int c, input int d, input int e);
    return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic set_lit(input logic [23:0] r, input int idx, input int st);
    l_on = 1; l_rgb = r; l_idx = idx; l_st = st;
  endtask

  task automatic check_out(input exp_t e);
    chk("rgb", 128'({red, green, blue}), 128'(e.rgb));
    chk("win_any", 128'(win_any), 128'(e.any));
    chk("win_idx", 128'(win_idx), 128'(e.idx));
    if (e.lit) begin
      chk("lit_rgb", 128'({red, green, blue}), 128'(e.lrgb));
      chk("lit_idx", 128'(win_idx), 128'(e.lidx));
    end
`ifdef OVL_STATS_EN
    begin
      logic [NL*CNTW-1:0] sv;
      if (e.fs) begin
        for (int k = 0; k < NL; k++) begin st_exp[k] = fcnt[k]; fcnt[k] = 0; end
        if (e.any) fcnt[e.idx] = 1;
      end else if (e.any && fcnt[e.idx] < (64'd1 << CNTW) - 1) begin
        fcnt[e.idx]++;
      end
      for (int k = 0; k < NL; k++) sv[k*CNTW +: CNTW] = CNTW'(st_exp[k]);
      chk("stat_valid", 128'(stat_valid), 128'(e.fs));
      chk("stat_cnt", 128'(stat_cnt), 128'(sv));
      if (e.lst >= 0) begin
        chk("lit_stat_valid", 128'(stat_valid), 128'(1));
        chk("lit_stat_cnt", 128'(stat_cnt), 128'(e.lst));
      end
    end
`endif
  endtask

  task automatic step(input logic [NL-1:0] en, input logic [NL*24-1:0] rgb, input logic [23:0] bg,
                      input logic v, input logic [NL*IW-1:0] cp);
    exp_t e;
    bit   rdy, fs;
    @(negedge clk);
    rdy = rdy_ok && !pend;
    chk("cfg_ready", 128'(cfg_ready), 128'(rdy));
    if (q.size() == 2) check_out(q.pop_front());
    rdy_ok = 1;
    cyc++;
    if (pend && fs_c >= 0 && cyc > fs_c) begin tbl = pend_tbl; pend = 0; end
    fs = (px == 0 && py == 0);
    if (v && rdy) begin
      for (int k = 0; k < NL; k++) pend_tbl[k] = int'(cp[k*IW +: IW]);
      pend = 1;
      fs_c = -1;
    end else if (pend && fs && fs_c < 0) begin
      fs_c = cyc;
    end
    pick(tbl, en, e.any, e.idx);
    e.rgb  = e.any ? rgb[e.idx*24 +: 24] : bg;
    e.fs   = fs;
    e.lit  = l_on;
    e.lrgb = l_rgb;
    e.lidx = l_idx;
    e.lst  = l_on ? l_st : -1;
    l_on   = 0;
    q.push_back(e);
    rst_n = 1; x = CW'(px); y = CW'(py);
    lay_en = en; lay_rgb = rgb; bg_rgb = bg; cfg_valid = v; cfg_prio = cp;
    px++;
    if (px == fw) begin px = 0; py = (py + 1) % fh; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; cfg_valid = 0; lay_en = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rgb", 128'({red, green, blue}), 128'(0));
      chk("rst_win", 128'({win_any, win_idx}), 128'(0));
      chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
`ifdef OVL_STATS_EN
      chk("rst_stat", 128'({stat_valid, stat_cnt}), 128'(0));
`endif
    end
    for (int k = 0; k < NL; k++) begin tbl[k] = k; fcnt[k] = 0; st_exp[k] = 0; end
    pend = 0; fs_c = -1; rdy_ok = 0; px = 0; py = 0; l_on = 0;
    q.delete();
  endtask

  logic [NL*24-1:0] rgb_a, rgb_b, rgb_r;

  initial begin
    fw = 6; fh = 4; cyc = 0;
    rgb_a = '0; rgb_a[24 +: 24] = 24'hFF0000; rgb_a[72 +: 24] = 24'h00FF00;
    rgb_b = '0; rgb_b[0 +: 24] = 24'h0000FF; rgb_b[48 +: 24] = 24'hABCDEF;
    do_reset();

    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 0, '0);
    set_lit(24'h123456, 0, -1); step(5'b00000, rgb_a, 24'h123456, 0, '0);

    // Deferred apply: layer1 holds through the fs pixel, layer3 from the next pixel.
    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 1, tab(3, 1, 0, 2, 4));
    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 1, tab(0, 1, 2, 3, 4));
    chk("cfg_ready_pend", 128'(cfg_ready), 128'(0));
    for (int i = 0; i < 40 && !(px == 0 && py == 0); i++) begin
      set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 1, tab(0, 1, 2, 3, 4));
    end
    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 0, '0);
    set_lit(24'h00FF00, 3, -1); step(5'b01010, rgb_a, 24'h0, 0, '0);
    step(5'b01010, rgb_a, 24'h0, 0, '0);
    chk("cfg_ready_after_apply", 128'(cfg_ready), 128'(1));

    // Out-of-range and duplicate entries.
    for (int i = 0; i < 10 && !pend; i++) step(5'b00000, rgb_b, 24'h0, 1, tab(7, 7, 2, 2, 0));
    for (int i = 0; i < 40 && !(px == 0 && py == 0); i++) step(5'b00000, rgb_b, 24'h0, 0, '0);
    step(5'b00000, rgb_b, 24'h0, 0, '0);
    set_lit(24'hABCDEF, 2, -1); step(5'b00101, rgb_b, 24'h0, 0, '0);
    step(5'b00000, rgb_b, 24'h0, 0, '0);
    step(5'b00000, rgb_b, 24'h0, 0, '0);

    // Reset while pending discards the loaded table.
    for (int i = 0; i < 10 && !pend; i++) step(5'b00000, rgb_a, 24'h0, 1, tab(3, 1, 0, 2, 4));
    step(5'b00000, rgb_a, 24'h0, 0, '0);
    do_reset();
    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 0, '0);
    set_lit(24'hFF0000, 1, -1); step(5'b01010, rgb_a, 24'h0, 0, '0);

    // 4x2 frame where layer0 claims three pixels.
    do_reset();
    fw = 4; fh = 2;
    for (int i = 0; i < 8; i++)
      step((i == 0 || i == 2 || i == 5) ? 5'b00001 : 5'b00000, rgb_b, 24'h111111, 0, '0);
    set_lit(24'h111111, 0, 3); step(5'b00000, rgb_b, 24'h111111, 0, '0);
    step(5'b00000, rgb_b, 24'h111111, 0, '0);
    step(5'b00000, rgb_b, 24'h111111, 0, '0);

    fw = 6; fh = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NL; k++) rgb_r[k*24 +: 24] = 24'($urandom);
      step(NL'($urandom), rgb_r, 24'($urandom), ($urandom_range(0, 3) == 0), (NL*IW)'($urandom));
    end
    step(5'b00000, rgb_r, 24'h0, 0, '0);
    step(5'b00000, rgb_r, 24'h0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
